// File: rtl/hdmi_scanout_if.sv
// hdmi_scanout_if: groups the scanout's RAM read ports, the PPU row-swap
// control and the video outputs toward the HDMI transmitter.
//   master : the scanout side (drives addresses, swap control, video)
//   slave  : RAMs / PPU / transmitter side (drives read data)
interface hdmi_scanout_if;
    logic [8:0]  rowram_rdaddr;
    logic [8:0]  rowram_rddata;
    logic [8:0]  palram_rdaddr;
    logic [23:0] palram_rddata;
    logic        rowram_swap;
    logic [7:0]  next_row;
    logic [23:0] vid_rgb;
    logic        vid_hsync;
    logic        vid_vsync;
    logic        vid_de;

    modport master (
        output rowram_rdaddr, input rowram_rddata,
        output palram_rdaddr, input palram_rddata,
        output rowram_swap, output next_row,
        output vid_rgb, output vid_hsync, output vid_vsync, output vid_de
    );

    modport slave (
        input  rowram_rdaddr, output rowram_rddata,
        input  palram_rdaddr, output palram_rddata,
        input  rowram_swap, input next_row,
        input  vid_rgb, input vid_hsync, input vid_vsync, input vid_de
    );
endinterface

// File: rtl/hdmi_scanout.sv
// hdmi_scanout: 640x480@60 scanout from the 50 MHz system clock.
// Reads the PPU's displayed row buffer, maps indices through the palette RAM
// and drives RGB/sync/DE. Each 320x240 game pixel is doubled in both axes.
// Also schedules PPU row-buffer flips (rowram_swap) and tells the PPU which
// game row to prepare next (next_row).
// Ports:
//   clk    : 50 MHz system clock
//   rst_n  : synchronous active-low reset
//   bus    : hdmi_scanout_if.master (row/palette RAM reads, swap control, video)
module hdmi_scanout #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned GAME_ROWS = 240
) (
    input  logic           clk,
    input  logic           rst_n,
    hdmi_scanout_if.master bus
);
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state, state_next;
    logic   init_fire;

    logic       pix_en;
    logic [9:0] h, v, h_next, v_next;
    logic       vis_next;
    logic       de, hs, vs;
    logic       de_d, hs_d, vs_d;
    logic       swap_line;
    logic [9:0] row_shown;
    logic [7:0] swap_row;

    // Init pulse: one swap on the first clock out of reset so the PPU starts
    // building row 0 well before the regular swap on the last frame line.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        init_fire  = 1'b0;
        case (state)
            ST_INIT: begin
                init_fire  = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        h_next = h + 10'd1;
        v_next = v;
        if (h == 10'(H_TOTAL - 1)) begin
            h_next = '0;
            v_next = (v == 10'(V_TOTAL - 1)) ? '0 : v + 10'd1;
        end
        vis_next = (h_next < 10'(H_VISIBLE)) && (v_next < 10'(V_VISIBLE));

        de = (h < 10'(H_VISIBLE)) && (v < 10'(V_VISIBLE));
        hs = !((h >= 10'(HS_START)) && (h < 10'(HS_END)));
        vs = !((v >= 10'(VS_START)) && (v < 10'(VS_END)));

        // Odd visible lines finish showing the lower copy of a game row; the
        // row after the one about to be displayed is what the PPU builds next.
        swap_line = (h == 10'(H_VISIBLE)) &&
                    ((v[0] && (v <= 10'(V_VISIBLE - 3))) || (v == 10'(V_TOTAL - 1)));
        row_shown = (v + 10'd1) >> 1;
        if (v == 10'(V_TOTAL - 1))                swap_row = 8'd1;
        else if (row_shown == 10'(GAME_ROWS - 1)) swap_row = '0;
        else                                      swap_row = 8'(row_shown + 10'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_en            <= 1'b0;
            h                 <= '0;
            v                 <= 10'(V_TOTAL - 3);
            de_d              <= 1'b0;
            hs_d              <= 1'b1;
            vs_d              <= 1'b1;
            bus.rowram_rdaddr <= '0;
            bus.palram_rdaddr <= '0;
            bus.rowram_swap   <= 1'b0;
            bus.next_row      <= '0;
            bus.vid_rgb       <= '0;
            bus.vid_hsync     <= 1'b1;
            bus.vid_vsync     <= 1'b1;
            bus.vid_de        <= 1'b0;
        end else begin
            pix_en          <= ~pix_en;
            bus.rowram_swap <= 1'b0;
            // Registered on the idle half so the pulse lands on the pix_en
            // cycle while h already reads H_VISIBLE.
            if (init_fire) begin
                bus.rowram_swap <= 1'b1;
                bus.next_row    <= '0;
            end else if (!pix_en && swap_line) begin
                bus.rowram_swap <= 1'b1;
                bus.next_row    <= swap_row;
            end
            if (pix_en) begin
                h                 <= h_next;
                v                 <= v_next;
                bus.rowram_rdaddr <= vis_next ? h_next[9:1] : '0;
                bus.palram_rdaddr <= bus.rowram_rddata;
                de_d              <= de;
                hs_d              <= hs;
                vs_d              <= vs;
                bus.vid_rgb       <= de_d ? bus.palram_rddata : '0;
                bus.vid_hsync     <= hs_d;
                bus.vid_vsync     <= vs_d;
                bus.vid_de        <= de_d;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_scanout.sv
// tb_hdmi_scanout: randomized-content bench for hdmi_scanout. A reduced
// geometry instance runs whole frames; a full 640x480 instance covers the
// start of a frame. Expected outputs come from a frame-position model.
module tb_hdmi_scanout;
    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, rows;
    } geom_t;

    typedef struct {
        logic [8:0]  ra, pa;
        logic        hs, vs, de, swap;
        logic [23:0] rgb;
        logic [7:0]  nr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ecount = -1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [8:0]  rowbuf [512];
    logic [23:0] pal    [512];
    geom_t gs, gf;

    hdmi_scanout_if sb ();
    hdmi_scanout_if fb ();

    hdmi_scanout #(
        .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(20), .V_FRONT(3), .V_SYNC(2), .V_BACK(3),
        .GAME_ROWS(10)
    ) u_small (.clk(clk), .rst_n(rst_n), .bus(sb));

    hdmi_scanout u_full (.clk(clk), .rst_n(rst_n), .bus(fb));

    always #5 clk = ~clk;

    // Edge index since the first clock that sampled rst_n high (0 = that edge).
    always @(posedge clk) ecount <= rst_n ? ecount + 1 : -1;

    // Synchronous-read RAM models shared by both instances.
    always @(posedge clk) begin
        sb.rowram_rddata <= rowbuf[sb.rowram_rdaddr];
        sb.palram_rddata <= pal[sb.palram_rdaddr];
        fb.rowram_rddata <= rowbuf[fb.rowram_rdaddr];
        fb.palram_rddata <= pal[fb.palram_rdaddr];
    end

    logic        sel_full = 1'b0;
    logic [8:0]  o_ra, o_pa;
    logic        o_hs, o_vs, o_de, o_swap;
    logic [23:0] o_rgb;
    logic [7:0]  o_nr;

    always_comb begin
        o_ra = sel_full ? fb.rowram_rdaddr : sb.rowram_rdaddr;
        o_pa = sel_full ? fb.palram_rdaddr : sb.palram_rdaddr;
        o_hs = sel_full ? fb.vid_hsync : sb.vid_hsync;
        o_vs = sel_full ? fb.vid_vsync : sb.vid_vsync;
        o_de = sel_full ? fb.vid_de : sb.vid_de;
        o_swap = sel_full ? fb.rowram_swap : sb.rowram_swap;
        o_rgb = sel_full ? fb.vid_rgb : sb.vid_rgb;
        o_nr = sel_full ? fb.next_row : sb.next_row;
    end

    function automatic int htot(geom_t g); return g.hv + g.hf + g.hs + g.hb; endfunction
    function automatic int vtot(geom_t g); return g.vv + g.vf + g.vs + g.vb; endfunction

    // Expected outputs after edge m. Counter position n (0 = reset point
    // h=0, v=V_TOTAL-3) occupies two clocks; video for n shows 4 clk later.
    function automatic exp_t model_at(geom_t g, int m);
        exp_t e;
        int ht, vt, n, h, v;
        ht = htot(g);
        vt = vtot(g);
        e.ra = '0; e.pa = '0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
        e.swap = 1'b0; e.rgb = '0; e.nr = '0;
        n = (m + 1) / 2; h = n % ht; v = (vt - 3 + n / ht) % vt;
        if (h < g.hv && v < g.vv) e.ra = 9'(h / 2);
        if (m >= 1) begin
            n = (m - 1) / 2; h = n % ht; v = (vt - 3 + n / ht) % vt;
            e.pa = (h < g.hv && v < g.vv) ? rowbuf[9'(h / 2)] : rowbuf[0];
        end
        if (m >= 3) begin
            n = (m - 3) / 2; h = n % ht; v = (vt - 3 + n / ht) % vt;
            e.de = (h < g.hv) && (v < g.vv);
            e.hs = !(h >= g.hv + g.hf && h < g.hv + g.hf + g.hs);
            e.vs = !(v >= g.vv + g.vf && v < g.vv + g.vf + g.vs);
            e.rgb = e.de ? pal[rowbuf[9'(h / 2)]] : 24'd0;
        end
        if (m == 0) begin
            e.swap = 1'b1;
            e.nr = 8'd0;
        end else if (m % 2 == 0) begin
            n = m / 2; h = n % ht; v = (vt - 3 + n / ht) % vt;
            if (h == g.hv && v % 2 == 1 && v <= g.vv - 3) begin
                e.swap = 1'b1;
                e.nr = 8'((((v + 1) / 2) + 1) % g.rows);
            end else if (h == g.hv && v == vt - 1) begin
                e.swap = 1'b1;
                e.nr = 8'd1;
            end
        end
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                sel_full = (s == 1);
                #0;
                n_checks++;
                if ({o_ra, o_pa, o_rgb, o_swap, o_nr, o_hs, o_vs, o_de} !== {9'd0, 9'd0, 24'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL reset_values dut=%0d: got ra=%0d pa=%0d rgb=%h swap=%b nr=%0d hs=%b vs=%b de=%b want all 0 except hs=vs=1",
                             s, o_ra, o_pa, o_rgb, o_swap, o_nr, o_hs, o_vs, o_de);
                end
            end
        end
    endtask

    task automatic test_free_run(input logic full, input int ncycles);
        geom_t g;
        exp_t e;
        logic [7:0] nr_exp;
        int frame, m, swaps, hs_low, vs_low, de_clk, de_lines;
        logic prev_de;
        g = full ? gf : gs;
        frame = 2 * htot(g) * vtot(g);
        sel_full = full;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nr_exp = '0;
        swaps = 0; hs_low = 0; vs_low = 0; de_clk = 0; de_lines = 0; prev_de = 1'b0;
        for (int c = 0; c < ncycles; c++) begin
            @(negedge clk);
            m = ecount;
            e = model_at(g, m);
            if (e.swap) nr_exp = e.nr;
            n_checks += 8;
            if (o_ra !== e.ra) begin n_fail++; $display("FAIL rowram_rdaddr m=%0d: got %0d want %0d", m, o_ra, e.ra); end
            if (o_pa !== e.pa) begin n_fail++; $display("FAIL palram_rdaddr m=%0d: got %0d want %0d", m, o_pa, e.pa); end
            if (o_hs !== e.hs) begin n_fail++; $display("FAIL vid_hsync m=%0d: got %b want %b", m, o_hs, e.hs); end
            if (o_vs !== e.vs) begin n_fail++; $display("FAIL vid_vsync m=%0d: got %b want %b", m, o_vs, e.vs); end
            if (o_de !== e.de) begin n_fail++; $display("FAIL vid_de m=%0d: got %b want %b", m, o_de, e.de); end
            if (o_rgb !== e.rgb) begin n_fail++; $display("FAIL vid_rgb m=%0d: got %h want %h", m, o_rgb, e.rgb); end
            if (o_swap !== e.swap) begin n_fail++; $display("FAIL rowram_swap m=%0d: got %b want %b", m, o_swap, e.swap); end
            if (o_nr !== nr_exp) begin n_fail++; $display("FAIL next_row m=%0d: got %0d want %0d", m, o_nr, nr_exp); end
            if (c < frame) swaps += int'(o_swap);
            if (c >= 8 && c < 8 + frame) begin
                hs_low += int'(!o_hs);
                vs_low += int'(!o_vs);
                de_clk += int'(o_de);
                if (o_de && !prev_de) de_lines++;
            end
            prev_de = o_de;
        end
        if (ncycles >= frame + 8) begin
            n_checks += 5;
            if (swaps != g.rows + 1) begin n_fail++; $display("FAIL swaps_first_frame: got %0d want %0d", swaps, g.rows + 1); end
            if (hs_low != 2 * g.hs * vtot(g)) begin n_fail++; $display("FAIL hsync_low_clk: got %0d want %0d", hs_low, 2 * g.hs * vtot(g)); end
            if (vs_low != 2 * g.vs * htot(g)) begin n_fail++; $display("FAIL vsync_low_clk: got %0d want %0d", vs_low, 2 * g.vs * htot(g)); end
            if (de_clk != 2 * g.hv * g.vv) begin n_fail++; $display("FAIL de_clk: got %0d want %0d", de_clk, 2 * g.hv * g.vv); end
            if (de_lines != g.vv) begin n_fail++; $display("FAIL de_lines: got %0d want %0d", de_lines, g.vv); end
        end
    endtask

    task automatic test_mid_reset();
        geom_t g;
        int ht, vt, n_t, n0, swaps, limit;
        logic hit;
        g = gs;
        ht = htot(g);
        vt = vtot(g);
        sel_full = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Midway position: half the visible lines, half the visible width.
        n_t = ((g.vv / 2 - (vt - 3) + vt) % vt) * ht + g.hv / 2;
        hit = 1'b0;
        limit = 4 * ht * vt;
        for (int c = 0; c < limit && !hit; c++) begin
            @(negedge clk);
            if (ecount == 2 * n_t) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL mid_reset_reach: got no hit want edge %0d", 2 * n_t); end
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({o_ra, o_pa, o_rgb, o_swap, o_nr, o_hs, o_vs, o_de} !== {9'd0, 9'd0, 24'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL mid_reset_values c=%0d: got ra=%0d pa=%0d rgb=%h swap=%b nr=%0d hs=%b vs=%b de=%b want reset values",
                         c, o_ra, o_pa, o_rgb, o_swap, o_nr, o_hs, o_vs, o_de);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_swap !== 1'b1 || o_nr !== 8'd0) begin
            n_fail++;
            $display("FAIL init_pulse: got swap=%b nr=%0d want swap=1 nr=0", o_swap, o_nr);
        end
        swaps = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            swaps += int'(o_swap);
        end
        n_checks++;
        if (swaps != 1) begin n_fail++; $display("FAIL init_pulse_width: got %0d want 1", swaps); end
        n0 = ((g.vv + g.vf - (vt - 3) + vt) % vt) * ht;
        hit = 1'b0;
        for (int c = 0; c < 2 * ht * vt + 50 && !hit; c++) begin
            @(negedge clk);
            if (o_vs === 1'b0) hit = 1'b1;
        end
        n_checks++;
        if (!hit || ecount != 2 * n0 + 3) begin
            n_fail++;
            $display("FAIL first_vsync_edge: got edge %0d (seen=%b) want %0d", ecount, hit, 2 * n0 + 3);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            rowbuf[i] = 9'($urandom_range(0, 511));
            pal[i] = 24'($urandom);
        end
        gs = '{40, 4, 8, 4, 20, 3, 2, 3, 10};
        gf = '{640, 16, 96, 48, 480, 10, 2, 33, 240};
        test_reset();
        test_free_run(1'b0, 2 * 2 * 56 * 28 + 20);
        test_mid_reset();
        test_free_run(1'b1, 8200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
